branch_comp_iter: RTL and testbench
===================================

# branch_comp_iter

Parametrised, iterative branch comparator for the RV32 core. It latches two WIDTH-bit operands and compares them MSB-first, CHUNK bits per cycle, honouring BrUn for signed or unsigned compare. It produces BrEq, BrLT and a funct3-decoded branch-taken flag behind a valid/ready handshake. It is the multi-cycle, width-generic replacement for the single-cycle branch comparator, for use in the area-reduced and pipelined core variants.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle. CHUNK must divide WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at the clock edge.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B.
- BrUn  input  1  1 = unsigned compare, 0 = two's-complement signed compare.
- funct3  input  3  branch funct3, used only for the taken/illegal decode.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready at the clock edge.
- BrEq  output  1  dataA == dataB.
- BrLT  output  1  dataA < dataB under the BrUn interpretation.
- taken  output  1  branch taken.
- illegal  output  1  funct3 is 010 or 011.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
  - in_ready = (state == IDLE) && !rst, combinational.
  - out_valid = (state == DONE), registered.
- IDLE:
  - On accept, latch dataA, dataB, BrUn and funct3.
  - Set idx = NCHUNK-1, clear the decided flag, go to BUSY.
- BUSY, each cycle:
  - Compare chunk idx of A against chunk idx of B as unsigned CHUNK-bit values.
  - When BrUn = 0 and idx = NCHUNK-1, invert the MSB of both chunks before comparing, which yields the signed order.
  - First unequal chunk:
    - Record BrEq = 0 and BrLT = (a_chunk < b_chunk), and set decided.
    - Later chunks never overwrite a decided result.
  - At idx = 0, if the result is still undecided, record BrEq = 1 and BrLT = 0.
  - Go to DONE after the final examined chunk; otherwise decrement idx.
- Taken decode by funct3, evaluated when entering DONE:
  - 000: taken = BrEq.
  - 001: taken = !BrEq.
  - 100 and 110: taken = BrLT.
  - 101 and 111: taken = !BrLT.
  - 010 and 011: illegal = 1, taken = 0. BrEq and BrLT are still valid.
- Signedness comes only from BrUn; funct3 does not override it.
- DONE:
  - BrEq, BrLT, taken and illegal hold stable until the handshake.
  - On out_ready, go to IDLE.
  - A new request is accepted no earlier than the cycle after the result handshake.
- While in BUSY or DONE, in_valid is ignored and in_ready = 0.
- Reset, at any time including mid-BUSY or mid-DONE:
  - Next state is IDLE; the in-flight request is dropped with no out_valid pulse.
  - out_valid, BrEq, BrLT, taken and illegal are all 0.
  - idx = NCHUNK-1.
- CHUNK == WIDTH is legal: NCHUNK = 1, one BUSY cycle.

## Timing
- Accept at edge t puts the FSM in BUSY during cycle t+1.
- Without the macro: out_valid is high from edge t+NCHUNK, fixed latency NCHUNK.
- With the macro: latency k, where k = number of chunks examined (1..NCHUNK) = NCHUNK − (index of the first differing chunk).
- Maximum throughput: one request per NCHUNK+2 cycles (accept, NCHUNK BUSY cycles, DONE), with out_ready tied high.
- Outputs are registered; there is no combinational path from the data inputs to any output.
- in_ready depends only on state and rst.

## Configuration
- BRCOMP_EARLY_EXIT_EN:
  - Defined: BUSY goes to DONE in the same cycle the first unequal chunk is found, giving variable latency.
  - Undefined: all NCHUNK chunks are always scanned, giving fixed latency NCHUNK.
- Results are identical in both builds; only latency differs.

## Test plan
All scenarios use WIDTH=32, CHUNK=8, and run in both macro builds unless noted.
- **Equal operands:** A=0x00000005, B=0x00000005, BrUn=0, funct3=000.
  - BrEq=1, BrLT=0, taken=1.
  - out_valid 4 cycles after accept in both builds.
- **Signed vs unsigned:** A=0xFFFFFFFF, B=0x00000001.
  - BrUn=0, funct3=100: BrLT=1, taken=1.
  - BrUn=1, funct3=110: BrLT=0, BrEq=0, taken=0.
  - Early-exit latency 1, otherwise 4.
- **Low-chunk difference:** A=0x12345600, B=0x12345700, BrUn=1, funct3=111.
  - BrLT=1, taken=0.
  - Early-exit latency 3.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE and drive in_valid=1 with new data.
  - Outputs stay constant and in_ready stays 0.
  - The new request is accepted only in the IDLE cycle after the result handshake.
- **Reset mid-operation:** assert rst for one cycle during the 2nd BUSY cycle.
  - Next cycle: IDLE, all outputs 0, no out_valid.
  - in_ready=1 the cycle after rst falls.
- **Illegal funct3:** funct3=010 with A=3, B=7, BrUn=0.
  - illegal=1, taken=0, BrLT=1, BrEq=0.

Source files
------------

// File: rtl/branch_comp_iter.sv
// Iterative MSB-first branch comparator, CHUNK bits per cycle, valid/ready.
// Optional BRCOMP_EARLY_EXIT_EN: finish at the first differing chunk.
module branch_comp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             BrUn,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             BrEq,
  output logic             BrLT,
  output logic             taken,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             un_q;
  logic [2:0]       f3_q;
  logic             dec_q;
  logic             lt_q;
  logic             breq_q;
  logic             brlt_q;
  logic             taken_q;
  logic             ill_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             diff;
  logic             hit;
  logic             dec_d;
  logic             lt_d;
  logic             fin;
  logic             eq_d;
  logic             tk_d;
  logic             ill_d;

  always_comb begin
    ca = a_q[int'(idx_q)*CHUNK +: CHUNK];
    cb = b_q[int'(idx_q)*CHUNK +: CHUNK];
    // Flipping the sign bit maps two's-complement order onto unsigned order
    if (!un_q && idx_q == TOP) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    diff  = (ca != cb);
    hit   = !dec_q && diff;
    dec_d = dec_q || diff;
    lt_d  = hit ? (ca < cb) : lt_q;
    eq_d  = !dec_d;
`ifdef BRCOMP_EARLY_EXIT_EN
    fin   = (idx_q == '0) || hit;
`else
    fin   = (idx_q == '0);
`endif
  end

  always_comb begin
    tk_d  = 1'b0;
    ill_d = 1'b0;
    unique case (f3_q)
      3'b000:          tk_d = eq_d;
      3'b001:          tk_d = !eq_d;
      3'b100, 3'b110:  tk_d = lt_d;
      3'b101, 3'b111:  tk_d = !lt_d;
      default:         ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= TOP;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      breq_q  <= 1'b0;
      brlt_q  <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= dataA;
            b_q     <= dataB;
            un_q    <= BrUn;
            f3_q    <= funct3;
            idx_q   <= TOP;
            dec_q   <= 1'b0;
            lt_q    <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          dec_q <= dec_d;
          lt_q  <= lt_d;
          if (fin) begin
            breq_q  <= eq_d;
            brlt_q  <= lt_d;
            taken_q <= tk_d;
            ill_q   <= ill_d;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            idx_q   <= TOP;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign BrEq      = breq_q;
  assign BrLT      = brlt_q;
  assign taken     = taken_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_branch_comp_iter.sv
// Directed + random bench for branch_comp_iter against an arithmetic model.
// Follows BRCOMP_EARLY_EXIT_EN for the expected latency.
module tb_branch_comp_iter;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic         BrUn = 1'b0;
  logic [2:0]   funct3 = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         BrEq;
  logic         BrLT;
  logic         taken;
  logic         illegal;

  int total = 0;
  int bad = 0;
  logic e_eq, e_lt, e_tk, e_il;

  always #5 clk = ~clk;

  branch_comp_iter #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB),
    .BrUn(BrUn), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .BrEq(BrEq), .BrLT(BrLT),
    .taken(taken), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
`ifdef BRCOMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) return N - i / C;
`endif
    return N;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic un, input logic [2:0] f3);
    e_eq = (a == b);
    e_lt = un ? (a < b) : ($signed(a) < $signed(b));
    e_il = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0: e_tk = e_eq;
      3'd1: e_tk = !e_eq;
      3'd4, 3'd6: e_tk = e_lt;
      3'd5, 3'd7: e_tk = !e_lt;
      default: e_tk = 1'b0;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns #1 after the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic un, input logic [2:0] f3);
    check("idle_ready", in_ready, 1);
    dataA = a; dataB = b; BrUn = un; funct3 = f3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dataA = $urandom; dataB = $urandom;
    BrUn = 1'($urandom); funct3 = 3'($urandom);
    model(a, b, un, f3);
  endtask

  task automatic await(input string tag, input int lat);
    int n;
    bit got;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) got = 1;
      else if (in_ready) begin
        check({tag, "_busy_rdy"}, in_ready, 0);
      end
    end
    check({tag, "_lat"}, n, lat);
    if (got) begin
      check({tag, "_eq"}, BrEq, e_eq);
      check({tag, "_lt"}, BrLT, e_lt);
      check({tag, "_tk"}, taken, e_tk);
      check({tag, "_il"}, illegal, e_il);
    end
  endtask

  task automatic release_res(input string tag, input int hold);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold"}, {out_valid, in_ready, BrEq, BrLT, taken, illegal},
            {1'b1, 1'b0, e_eq, e_lt, e_tk, e_il});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run(input string tag, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic un,
                     input logic [2:0] f3, input int hold);
    send(a, b, un, f3);
    await(tag, ref_lat(a, b));
    release_res(tag, hold);
  endtask

  initial begin
    logic [W-1:0] ra, rb, m;
    int nk;
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outs", {out_valid, BrEq, BrLT, taken, illegal}, 0);
    check("rst_ready_after", in_ready, 1);

    run("equal", 32'h5, 32'h5, 1'b0, 3'b000, 0);
    run("signed", 32'hFFFF_FFFF, 32'h1, 1'b0, 3'b100, 0);
    run("unsigned", 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b110, 1);
    run("lowchunk", 32'h1234_5600, 32'h1234_5700, 1'b1, 3'b111, 0);
    run("illegal", 32'h3, 32'h7, 1'b0, 3'b010, 0);
    run("illegal3", 32'h9, 32'h9, 1'b1, 3'b011, 0);
    run("bne", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, 0);

    // Backpressure: new request presented while the result is held
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 3'b101);
    await("bp", ref_lat(32'h8000_0000, 32'h0000_0001));
    dataA = 32'h0000_00AA; dataB = 32'h0000_00AA;
    BrUn = 1'b1; funct3 = 3'b000;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, BrEq, BrLT, taken, illegal},
            {1'b1, 1'b0, e_eq, e_lt, e_tk, e_il});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1 in_valid = 1'b0;
    model(32'h0000_00AA, 32'h0000_00AA, 1'b1, 3'b000);
    await("bp_next", N);
    release_res("bp_next", 0);

    // Reset during the second BUSY cycle; prior result left outputs high
    run("pre_rst", 32'h5, 32'h5, 1'b0, 3'b000, 0);
    send(32'h0000_0010, 32'h0000_0020, 1'b1, 3'b100);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {out_valid, BrEq, BrLT, taken, illegal}, 0);
    check("rst_mid_ready_after", in_ready, 1);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_valid", out_valid, 0);
    end

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      nk = $urandom_range(0, N);
      m = '0;
      for (int j = 0; j < nk; j++) m[W-1-j*C -: C] = '1;
      rb = (rb & ~m) | (ra & m);
      run("rand", ra, rb, 1'($urandom), 3'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
